// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO family: depth computation and
// threshold legality. Pointer types are sized per instance inside each module.
package fifo_pkg;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  function automatic bit thr_legal(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DSIZE storage: synchronous write port, asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  localparam int DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo2.sv
// Single-clock FIFO with optional first-word-fall-through, almost-full/empty
// thresholds, occupancy count, synchronous flush and sticky error flags.
module sync_fifo2
  import fifo_pkg::*;
#(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 3,
  parameter bit FWFT       = 1'b0,
  parameter int AFULL_THR  = fifo_depth(ASIZE) - 2,
  parameter int AEMPTY_THR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = fifo_depth(ASIZE);

  typedef logic [ASIZE:0] ptr_t;

  localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
  localparam ptr_t AFULL_P  = ptr_t'(AFULL_THR);
  localparam ptr_t AEMPTY_P = ptr_t'(AEMPTY_THR);

  if (!thr_legal(DEPTH, AFULL_THR, AEMPTY_THR)) begin : g_bad_thr
    $error("sync_fifo2: AFULL_THR must be 1..DEPTH and AEMPTY_THR 0..DEPTH-1");
  end

  ptr_t             r_wptr, r_rptr, r_count;
  logic             r_full, r_afull, r_empty, r_aempty, r_ovf, r_udf;
  logic             w_wr_acc, w_rd_acc;
  ptr_t             w_wptr_nxt, w_rptr_nxt, w_count_nxt;
  logic [DSIZE-1:0] w_mem_rdata;

  // Flush wins over both requests; full/empty gate acceptance on registered flags.
  always_comb begin
    w_wr_acc    = winc && !r_full && !clr;
    w_rd_acc    = rinc && !r_empty && !clr;
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    if (clr) begin
      w_wptr_nxt = '0;
      w_rptr_nxt = '0;
    end else begin
      if (w_wr_acc) w_wptr_nxt = r_wptr + ptr_t'(1);
      if (w_rd_acc) w_rptr_nxt = r_rptr + ptr_t'(1);
    end
    w_count_nxt = w_wptr_nxt - w_rptr_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DEPTH_P);
      r_afull  <= (w_count_nxt >= AFULL_P);
      r_empty  <= (w_count_nxt == '0);
      r_aempty <= (w_count_nxt <= AEMPTY_P);
      if (winc && r_full && !clr)  r_ovf <= 1'b1;
      if (rinc && r_empty && !clr) r_udf <= 1'b1;
    end
  end

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (w_mem_rdata)
  );

  if (FWFT) begin : g_fwft
    assign rdata = r_empty ? '0 : w_mem_rdata;
  end else begin : g_reg_rd
    logic [DSIZE-1:0] r_rdata;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_rdata <= '0;
      else if (w_rd_acc) r_rdata <= w_mem_rdata;
    end
    assign rdata = r_rdata;
  end

  assign count         = r_count;
  assign wfull         = r_full;
  assign walmost_full  = r_afull;
  assign rempty        = r_empty;
  assign ralmost_empty = r_aempty;
  assign overflow      = r_ovf;
  assign underflow     = r_udf;

endmodule

// File: tb/tb_sync_fifo2.sv
// Bench for sync_fifo2: a registered-read and a FWFT instance share one stimulus
// stream and are checked against a queue-based reference model.
module tb_sync_fifo2;

  localparam int DEPTH = 8;

  logic       clk, rst, clr, winc, rinc;
  logic [7:0] wdata;

  logic       wfull0, wafull0, rempty0, raempty0, ovf0, udf0;
  logic [7:0] rdata0;
  logic [3:0] count0;
  logic       wfull1, wafull1, rempty1, raempty1, ovf1, udf1;
  logic [7:0] rdata1;
  logic [3:0] count1;

  sync_fifo2 #(.DSIZE(8), .ASIZE(3), .FWFT(1'b0), .AFULL_THR(6), .AEMPTY_THR(1)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .winc(winc), .wdata(wdata),
    .wfull(wfull0), .walmost_full(wafull0), .rinc(rinc), .rdata(rdata0),
    .rempty(rempty0), .ralmost_empty(raempty0), .count(count0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo2 #(.DSIZE(8), .ASIZE(3), .FWFT(1'b1), .AFULL_THR(6), .AEMPTY_THR(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .winc(winc), .wdata(wdata),
    .wfull(wfull1), .walmost_full(wafull1), .rinc(rinc), .rdata(rdata1),
    .rempty(rempty1), .ralmost_empty(raempty1), .count(count1),
    .overflow(ovf1), .underflow(udf1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model and scoreboard state
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         m_ovf, m_udf;
  int         total, bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Predicts one clock edge: pop happens before push, acceptance uses pre-edge occupancy.
  task automatic model_step(input bit w, input logic [7:0] d, input bit r, input bit c);
    int n;
    n = model_q.size();
    if (c) begin
      model_q.delete();
    end else begin
      if (w && n == DEPTH) m_ovf = 1'b1;
      if (r && n == 0)     m_udf = 1'b1;
      if (r && n > 0)      exp_q.push_back(model_q.pop_front());
      if (w && n < DEPTH)  model_q.push_back(d);
    end
  endtask

  task automatic check_status(input string tag, input bit chk_rd0);
    int n;
    logic [5:0] exp_flags;
    n = model_q.size();
    exp_flags = {n == DEPTH, n >= 6, n == 0, n <= 1, m_ovf, m_udf};
    chk({tag, ":count0"},  32'(count0),   32'(n));
    chk({tag, ":wfull0"},  32'(wfull0),   32'(n == DEPTH));
    chk({tag, ":wafull0"}, 32'(wafull0),  32'(n >= 6));
    chk({tag, ":rempty0"}, 32'(rempty0),  32'(n == 0));
    chk({tag, ":raempty0"},32'(raempty0), 32'(n <= 1));
    chk({tag, ":ovf0"},    32'(ovf0),     32'(m_ovf));
    chk({tag, ":udf0"},    32'(udf0),     32'(m_udf));
    chk({tag, ":count1"},  32'(count1),   32'(n));
    chk({tag, ":flags1"},  32'({wfull1, wafull1, rempty1, raempty1, ovf1, udf1}), 32'(exp_flags));
    chk({tag, ":rdata1"},  32'(rdata1),   (n == 0) ? 32'h0 : 32'(model_q[0]));
    if (chk_rd0) chk({tag, ":rdata0"}, 32'(rdata0), 32'h0);
  endtask

  // driver: check the state left by the previous edge, then present the next request
  task automatic cycle(input string tag, input bit w, input logic [7:0] d, input bit r, input bit c);
    @(negedge clk);
    check_status(tag, 1'b0);
    winc  = w;
    wdata = d;
    rinc  = r;
    clr   = c;
    model_step(w, d, r, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    winc = 1'b0; rinc = 1'b0; clr = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_status("sync_rst", 1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: a registered-read pop shows up on rdata0 after the edge that accepted it
  initial begin
    bit         pend;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      pend = rinc && !rempty0 && !clr && !rst;
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rdata0_unexpected got=%0h want=<no pop expected> @%0t", rdata0, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rdata0", 32'(rdata0), 32'(e));
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
    model_reset();
    #1;
    check_status("reset", 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // fill to full, then one write too many
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    cycle("ovf", 1'b1, 8'hFF, 1'b0, 1'b0);
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // drain everything, then one read too many
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("udf", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // fall-through visibility of a single word
    cycle("fwft_w", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("fwft_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("fwft_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // simultaneous write/read at count 4, then at count 0
    do_reset();
    for (int i = 0; i < 4; i++) cycle("pre4", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("wr_rd", 1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain4", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("wr_rd0", 1'b1, 8'h55, 1'b1, 1'b0);
    cycle("rd1", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // random traffic: write-biased, balanced, then read-biased so it wraps and hits both ends
    for (int i = 0; i < 60; i++)
      cycle("rnd_w", $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0, 1'b0);
    for (int i = 0; i < 60; i++)
      cycle("rnd_m", $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, 1'b0);
    for (int i = 0; i < 60; i++)
      cycle("rnd_r", $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, 1'b0);
    for (int i = 0; i < 10; i++) cycle("flush_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // flush at count 5 with a competing write
    do_reset();
    for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    cycle("clr", 1'b1, 8'hEE, 1'b0, 1'b1);
    cycle("post_clr", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("w_after_clr", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // asynchronous reset in the middle of a write cycle
    @(negedge clk);
    check_status("pre_rst", 1'b0);
    winc = 1'b1; wdata = 8'h77; rinc = 1'b0; clr = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_status("async_rst", 1'b1);
    @(negedge clk);
    rst = 1'b0;
    winc = 1'b0;

    // still functional after reset
    cycle("w_after_rst", 1'b1, 8'h9A, 1'b0, 1'b0);
    cycle("w_after_rst", 1'b1, 8'h9B, 1'b0, 1'b0);
    cycle("r_after_rst", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("r_after_rst", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check_status("final", 1'b0);
    chk("pending_pops", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
